// File: rtl/cic_ch_scheduler_pkg.sv
// Shared definitions for the CIC channel scheduler: FSM encoding, config
// limits and the channel-index width used by the top and its arbiter.
package cic_ch_scheduler_pkg;

  localparam int MAX_DCEF = 255;
  localparam int CH_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE_HI  = 3'd1,
    ST_ISSUE_LO  = 3'd2,
    ST_CFG_START = 3'd3,
    ST_CFG_WAIT  = 3'd4
  } sched_state_e;

  // Round-robin pointer advance: one past the granted channel, wrapping at num_ch.
  function automatic logic [CH_IDX_W-1:0] wrap_inc(input logic [CH_IDX_W-1:0] idx,
                                                   input int num_ch);
    if (int'(idx) >= num_ch - 1) return '0;
    else return idx + CH_IDX_W'(1);
  endfunction

endpackage

// File: rtl/cic_ch_scheduler_arb.sv
// Round-robin arbiter: picks the lowest requesting channel at or above rr_ptr,
// falling back to the lowest requesting channel overall when none is above.
module cic_rr_arbiter
  import cic_ch_scheduler_pkg::*;
#(
  parameter int NUM_CH = 16
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_IDX_W-1:0] rr_ptr,
  output logic [NUM_CH-1:0]   grant,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                any
);

  logic [CH_IDX_W-1:0] hi_idx;
  logic [CH_IDX_W-1:0] lo_idx;
  logic                hi_any;
  logic                lo_any;

  // Descending scan so the last hit written is the lowest index.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = CH_IDX_W'(i);
        lo_any = 1'b1;
        if (CH_IDX_W'(i) >= rr_ptr) begin
          hi_idx = CH_IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant     = '0;
    any       = lo_any;
    grant_idx = hi_any ? hi_idx : lo_idx;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lo_any && (CH_IDX_W'(i) == grant_idx)) grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cic_ch_scheduler.sv
// Schedules per-channel samples into a shared CIC decimator, one sample every
// three cycles, and interleaves decimation-factor reconfiguration requests.
module cic_ch_scheduler
  import cic_ch_scheduler_pkg::*;
#(
  parameter int MIDDLE_WIDTH = 37,
  parameter int NUM_CH       = 16,
  parameter int CFG_WIDTH    = 16,
  parameter int CFG_TIMEOUT  = 8
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*MIDDLE_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            ch_ack,
  input  logic                         cfg_req,
  input  logic [CFG_WIDTH-1:0]         cfg_dcef,
  output logic                         cfg_busy,
  output logic                         cfg_err,
  output logic                         cic_isConfig,
  output logic [CFG_WIDTH-1:0]         cic_Data_Config_In,
  input  logic                         cic_isConfigDone,
  output logic [MIDDLE_WIDTH-1:0]      cic_Data_In,
  output logic                         cic_Data_In_Valid,
  output logic [CH_IDX_W-1:0]          cic_Data_In_ChIdx
);

  localparam int TMR_W = $clog2(CFG_TIMEOUT + 1);

  sched_state_e          state;
  logic [CH_IDX_W-1:0]   rr_ptr;
  logic [CFG_WIDTH-1:0]  dcef_q;
  logic                  cfg_pending;
  logic [TMR_W-1:0]      timer;

  logic [NUM_CH-1:0]     arb_grant;
  logic [CH_IDX_W-1:0]   arb_idx;
  logic                  arb_any;
  logic [MIDDLE_WIDTH-1:0] sel_data;
  logic                  cfg_take;
  logic                  cfg_ok;

  cic_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (ch_req & ch_en),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) sel_data = ch_data[i*MIDDLE_WIDTH +: MIDDLE_WIDTH];
    end
  end

  assign cfg_take = cfg_req && !cfg_busy;
  assign cfg_ok   = (cfg_dcef != '0) && (cfg_dcef <= CFG_WIDTH'(MAX_DCEF));

  // All outputs are registered, so each pulse appears the cycle after the
  // state that decides it: ack while in ISSUE_HI, Valid while in ISSUE_LO.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state              <= ST_IDLE;
      rr_ptr             <= '0;
      dcef_q             <= '0;
      cfg_pending        <= 1'b0;
      timer              <= '0;
      ch_ack             <= '0;
      cfg_busy           <= 1'b0;
      cfg_err            <= 1'b0;
      cic_isConfig       <= 1'b0;
      cic_Data_Config_In <= '0;
      cic_Data_In        <= '0;
      cic_Data_In_Valid  <= 1'b0;
      cic_Data_In_ChIdx  <= '0;
    end else begin
      ch_ack            <= '0;
      cfg_err           <= 1'b0;
      cic_isConfig      <= 1'b0;
      cic_Data_In_Valid <= 1'b0;

      if (cfg_take) begin
        if (cfg_ok) begin
          cfg_busy    <= 1'b1;
          cfg_pending <= 1'b1;
          dcef_q      <= cfg_dcef;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (cfg_pending || (cfg_take && cfg_ok)) begin
            state              <= ST_CFG_START;
            cic_isConfig       <= 1'b1;
            cic_Data_Config_In <= cfg_pending ? dcef_q : cfg_dcef;
            cfg_pending        <= 1'b0;
          end else if (arb_any) begin
            state             <= ST_ISSUE_HI;
            ch_ack            <= arb_grant;
            cic_Data_In       <= sel_data;
            cic_Data_In_ChIdx <= arb_idx;
            rr_ptr            <= wrap_inc(arb_idx, NUM_CH);
          end
        end
        ST_ISSUE_HI: begin
          cic_Data_In_Valid <= 1'b1;
          state             <= ST_ISSUE_LO;
        end
        ST_ISSUE_LO: state <= ST_IDLE;
        ST_CFG_START: begin
          timer <= '0;
          state <= ST_CFG_WAIT;
        end
        ST_CFG_WAIT: begin
          if (cic_isConfigDone) begin
            cfg_busy <= 1'b0;
            state    <= ST_IDLE;
          end else if (timer == TMR_W'(CFG_TIMEOUT - 1)) begin
            cfg_err  <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_ch_scheduler.sv
// Self-checking bench for cic_ch_scheduler: directed scenarios plus random
// traffic compared against a timeline-based reference model.
module tb_cic_ch_scheduler;

  localparam int NCH = 16;
  localparam int MW  = 37;
  localparam int CW  = 16;

  logic              CLK;
  logic              nRST;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_en;
  logic [NCH*MW-1:0] ch_data;
  logic [NCH-1:0]    ch_ack;
  logic              cfg_req;
  logic [CW-1:0]     cfg_dcef;
  logic              cfg_busy;
  logic              cfg_err;
  logic              cic_isConfig;
  logic [CW-1:0]     cic_Data_Config_In;
  logic              cic_isConfigDone;
  logic [MW-1:0]     cic_Data_In;
  logic              cic_Data_In_Valid;
  logic [3:0]        cic_Data_In_ChIdx;

  int num_vectors;
  int num_miscompares;

  // Reference model: everything is expressed as edge numbers on a timeline.
  int            n;
  int            rr;
  int            free_at;
  int            last_grant;
  int            cfg_start;
  bit            in_cfg;
  bit            pend;
  bit            busy;
  logic [CW-1:0] dcef_l;
  logic [CW-1:0] exp_cfg_out;
  logic [NCH-1:0] exp_ack;
  logic [3:0]    exp_idx;
  logic [MW-1:0] exp_data;
  bit            exp_err;
  bit            exp_valid;
  bit            exp_isc;

  cic_ch_scheduler #(
    .MIDDLE_WIDTH(MW), .NUM_CH(NCH), .CFG_WIDTH(CW), .CFG_TIMEOUT(8)
  ) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .ch_req             (ch_req),
    .ch_en              (ch_en),
    .ch_data            (ch_data),
    .ch_ack             (ch_ack),
    .cfg_req            (cfg_req),
    .cfg_dcef           (cfg_dcef),
    .cfg_busy           (cfg_busy),
    .cfg_err            (cfg_err),
    .cic_isConfig       (cic_isConfig),
    .cic_Data_Config_In (cic_Data_Config_In),
    .cic_isConfigDone   (cic_isConfigDone),
    .cic_Data_In        (cic_Data_In),
    .cic_Data_In_Valid  (cic_Data_In_Valid),
    .cic_Data_In_ChIdx  (cic_Data_In_ChIdx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_vectors++;
    if (obs !== exp) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic modelReset();
    n           = 0;
    rr          = 0;
    free_at     = 0;
    last_grant  = -10;
    cfg_start   = -100;
    in_cfg      = 0;
    pend        = 0;
    busy        = 0;
    dcef_l      = '0;
    exp_cfg_out = '0;
    exp_ack     = '0;
    exp_idx     = '0;
    exp_data    = '0;
    exp_err     = 0;
    exp_valid   = 0;
    exp_isc     = 0;
  endtask

  task automatic modelStep(input logic [NCH-1:0] req, input logic [NCH-1:0] en,
                           input logic cr, input logic [CW-1:0] dc, input logic dn);
    logic [NCH-1:0] masked;
    int pick;
    exp_ack = '0;
    exp_err = 0;
    if (cr && !busy) begin
      if (dc == 0 || dc > 255) exp_err = 1;
      else begin
        busy   = 1;
        pend   = 1;
        dcef_l = dc;
      end
    end
    if (in_cfg && n >= cfg_start + 2) begin
      if (dn) begin
        in_cfg = 0; busy = 0; free_at = n + 1;
      end else if (n == cfg_start + 9) begin
        exp_err = 1; in_cfg = 0; busy = 0; free_at = n + 1;
      end
    end else if (!in_cfg && n >= free_at) begin
      if (pend) begin
        pend        = 0;
        in_cfg      = 1;
        cfg_start   = n;
        exp_cfg_out = dcef_l;
      end else begin
        masked = req & en;
        pick   = -1;
        for (int k = 0; k < NCH; k++) begin
          if (pick < 0 && masked[(rr + k) % NCH]) pick = (rr + k) % NCH;
        end
        if (pick >= 0) begin
          exp_ack[pick] = 1'b1;
          exp_idx       = 4'(pick);
          exp_data      = ch_data[pick*MW +: MW];
          last_grant    = n;
          free_at       = n + 3;
          rr            = (pick + 1) % NCH;
        end
      end
    end
    exp_valid = (n == last_grant + 1);
    exp_isc   = (n == cfg_start);
    n++;
  endtask

  task automatic compareAll();
    checkOutput("ch_ack",     64'(ch_ack),             64'(exp_ack));
    checkOutput("valid",      64'(cic_Data_In_Valid),  64'(exp_valid));
    checkOutput("chidx",      64'(cic_Data_In_ChIdx),  64'(exp_idx));
    checkOutput("data",       64'(cic_Data_In),        64'(exp_data));
    checkOutput("isConfig",   64'(cic_isConfig),       64'(exp_isc));
    checkOutput("config_in",  64'(cic_Data_Config_In), 64'(exp_cfg_out));
    checkOutput("cfg_busy",   64'(cfg_busy),           64'(busy));
    checkOutput("cfg_err",    64'(cfg_err),            64'(exp_err));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"},   64'(ch_ack), 64'd0);
    checkOutput({tag, "_valid"}, 64'(cic_Data_In_Valid), 64'd0);
    checkOutput({tag, "_data"},  64'(cic_Data_In), 64'd0);
    checkOutput({tag, "_idx"},   64'(cic_Data_In_ChIdx), 64'd0);
    checkOutput({tag, "_isc"},   64'(cic_isConfig), 64'd0);
    checkOutput({tag, "_cfgin"}, 64'(cic_Data_Config_In), 64'd0);
    checkOutput({tag, "_busy"},  64'(cfg_busy), 64'd0);
    checkOutput({tag, "_err"},   64'(cfg_err), 64'd0);
  endtask

  // Called at a falling edge; drives inputs, steps the model at the rising
  // edge and compares at the next falling edge.
  task automatic applyStimulus(input logic [NCH-1:0] req, input logic [NCH-1:0] en,
                               input logic cr, input logic [CW-1:0] dc, input logic dn);
    ch_req           = req;
    ch_en            = en;
    cfg_req          = cr;
    cfg_dcef         = dc;
    cic_isConfigDone = dn;
    @(posedge CLK);
    modelStep(req, en, cr, dc, dn);
    @(negedge CLK);
    compareAll();
  endtask

  task automatic randomizeData();
    logic [63:0] r;
    for (int i = 0; i < NCH; i++) begin
      r = {$urandom(), $urandom()};
      ch_data[i*MW +: MW] = r[MW-1:0];
    end
  endtask

  initial begin
    logic [NCH-1:0] rq;
    logic [NCH-1:0] en;
    logic [CW-1:0]  dc;
    num_vectors     = 0;
    num_miscompares = 0;
    modelReset();
    nRST             = 1'b0;
    ch_req           = '0;
    ch_en            = '0;
    cfg_req          = 1'b0;
    cfg_dcef         = '0;
    cic_isConfigDone = 1'b0;
    randomizeData();
    #3;
    checkAllZero("reset");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Single channel grant with a known sample.
    ch_data[0 +: MW] = 37'h5;
    applyStimulus(16'h0001, 16'hFFFF, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 16'hFFFF, 1'b0, '0, 1'b0);

    // Two contending channels alternate.
    for (int i = 0; i < 12; i++) applyStimulus(16'h8001, 16'hFFFF, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 16'hFFFF, 1'b0, '0, 1'b0);

    // Config arriving while a sample is in flight, acknowledged after 2 cycles.
    applyStimulus(16'h0002, 16'hFFFF, 1'b0, '0, 1'b0);
    applyStimulus(16'h0002, 16'hFFFF, 1'b1, 16'd8, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(16'h0002, 16'hFFFF, 1'b0, '0, 1'b0);
    applyStimulus(16'h0002, 16'hFFFF, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0002, 16'hFFFF, 1'b0, '0, 1'b0);

    // Rejected factors, then a timeout, with a masked channel requesting.
    applyStimulus(16'h0010, 16'hFFEF, 1'b1, 16'd0, 1'b0);
    applyStimulus(16'h0010, 16'hFFEF, 1'b0, '0, 1'b0);
    applyStimulus(16'h0010, 16'hFFEF, 1'b1, 16'd300, 1'b0);
    applyStimulus(16'h0010, 16'hFFEF, 1'b0, '0, 1'b0);
    applyStimulus('0, 16'hFFFF, 1'b1, 16'd4, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(16'h0001, 16'hFFFF, 1'b0, '0, 1'b0);

    // Reset while waiting for config acknowledge.
    applyStimulus('0, 16'hFFFF, 1'b1, 16'd9, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 16'hFFFF, 1'b0, '0, 1'b0);
    #2 nRST = 1'b0;
    #1 checkAllZero("midreset");
    @(negedge CLK);
    nRST = 1'b1;
    modelReset();
    applyStimulus(16'h0004, 16'hFFFF, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 16'hFFFF, 1'b0, '0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) randomizeData();
      rq = 16'($urandom());
      if ($urandom_range(0, 1) == 0) rq = rq & 16'($urandom());
      en = 16'($urandom()) | 16'($urandom());
      case ($urandom_range(0, 3))
        0:       dc = '0;
        1:       dc = 16'($urandom_range(256, 400));
        default: dc = 16'($urandom_range(1, 255));
      endcase
      applyStimulus(rq, en, ($urandom_range(0, 9) == 0), dc, ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/cic_ch_scheduler.md
CIC_CH_SCHEDULER -- requirements
Module: cic_ch_scheduler

Interface
REQ-001 SHALL have parameter MIDDLE_WIDTH, default 37, sample width passed to the CIC decimator.
REQ-002 SHALL have parameter NUM_CH, default 16, number of requesting channels (max 16).
REQ-003 SHALL have parameter CFG_WIDTH, default 16, decimation-factor config word width.
REQ-004 SHALL have parameter CFG_TIMEOUT, default 8, cycles to wait for config acknowledge.
REQ-005 SHALL have one clock, CLK, input, 1, all logic on its rising edge.
REQ-006 SHALL have reset nRST, input, 1, asynchronous, active-low.
REQ-007 SHALL have ch_req, input, NUM_CH, per-channel sample-ready level.
REQ-008 SHALL have ch_en, input, NUM_CH, per-channel enable mask.
REQ-009 SHALL have ch_data, input, NUM_CH*MIDDLE_WIDTH, channel i sample at bits [i*MIDDLE_WIDTH +: MIDDLE_WIDTH].
REQ-010 SHALL have ch_ack, output, NUM_CH, one-cycle one-hot grant pulse.
REQ-011 SHALL have cfg_req, input, 1, pulse requesting a new decimation factor.
REQ-012 SHALL have cfg_dcef, input, CFG_WIDTH, decimation factor, sampled with cfg_req.
REQ-013 SHALL have cfg_busy, output, 1, high from accepted cfg_req until config completes.
REQ-014 SHALL have cfg_err, output, 1, one-cycle pulse on rejected or timed-out config.
REQ-015 SHALL have cic_isConfig, output, 1; cic_Data_Config_In, output, CFG_WIDTH; cic_isConfigDone, input, 1.
REQ-016 SHALL have cic_Data_In, output, MIDDLE_WIDTH; cic_Data_In_Valid, output, 1; cic_Data_In_ChIdx, output, 4.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE_HI, ISSUE_LO, CFG_START, CFG_WAIT.
REQ-018 IDLE: pending config takes priority; else if any (ch_req & ch_en) set, grant one channel and go to ISSUE_HI next cycle.
REQ-019 Grant SHALL be round-robin: lowest index >= rr_ptr with req&en, wrapping at NUM_CH-1 to 0; rr_ptr becomes granted index+1 (mod NUM_CH).
REQ-020 On grant cycle, ch_ack[i] SHALL pulse for exactly one cycle and cic_Data_In / cic_Data_In_ChIdx SHALL load ch_data slice i and i.
REQ-021 ISSUE_HI: cic_Data_In_Valid=1 for one cycle; ISSUE_LO: Valid=0 for one cycle; then IDLE.
REQ-022 cic_Data_In and cic_Data_In_ChIdx SHALL hold stable from grant until next grant (covers downstream falling-edge capture).
REQ-023 Throughput SHALL be max one sample per 3 cycles (IDLE, ISSUE_HI, ISSUE_LO); grant-to-Valid-rise latency 1 cycle.
REQ-024 cfg_req SHALL be accepted in any state when cfg_busy=0; cfg_dcef latched; cfg_req while cfg_busy=1 SHALL be ignored.
REQ-025 cfg_dcef==0 or cfg_dcef>255 SHALL be rejected: cfg_err pulse next cycle, no cic_isConfig, cfg_busy stays 0.
REQ-026 Accepted config SHALL wait for any in-flight ISSUE_HI/ISSUE_LO to complete, then enter CFG_START.
REQ-027 CFG_START: cic_isConfig=1 for one cycle with cic_Data_Config_In=latched dcef; go to CFG_WAIT.
REQ-028 cic_Data_Config_In SHALL hold latched value from CFG_START through end of CFG_WAIT.
REQ-029 CFG_WAIT: on cic_isConfigDone=1 clear cfg_busy, go IDLE; after CFG_TIMEOUT cycles without it, pulse cfg_err, clear cfg_busy, go IDLE.
REQ-030 No ch_ack SHALL be issued while cfg_busy=1.
REQ-031 Simultaneous cfg_req and channel request in IDLE: config wins, no grant that cycle.
REQ-032 Requests with ch_en=0 SHALL never be granted; rr_ptr unaffected by masked channels.

Reset
REQ-033 On nRST low, immediately: state IDLE, rr_ptr 0, all outputs 0, latched dcef 0, timeout counter 0, pending config cleared.
REQ-034 Reset mid-issue or mid-config SHALL abort with no further Valid or isConfig pulses.

Structure
REQ-035 Shared package/header SHALL hold FSM state encodings, MAX_DCEF=255 and channel-index width 4.
REQ-036 One sub-module cic_rr_arbiter (req&en, rr_ptr -> one-hot grant, index, any) is natural.

Verification
REQ-037 Reset then ch_req=16'h0001, ch_en=16'hFFFF, ch_data[0]=37'h5 -> ch_ack[0] pulse, Valid 1 next cycle, ChIdx 0, Data 0x5.
REQ-038 ch_req=16'h8001 held, rr_ptr=0 -> grants 0,15,0,15 one every 3 cycles.
REQ-039 cfg_req with dcef=8 during ISSUE_HI -> ISSUE_LO completes, isConfig one pulse, Config_In=8; done after 2 cycles -> cfg_busy falls, grants resume.
REQ-040 cfg_req dcef=0, then dcef=300 -> cfg_err pulse each, isConfig never asserted.
REQ-041 cfg_req dcef=4, isConfigDone held 0 -> cfg_err pulse 8 cycles after CFG_WAIT entry, cfg_busy falls.
REQ-042 nRST low during CFG_WAIT -> all outputs 0 at once; after release, ch_req=16'h0004 -> grant index 2.
